lcd_frame_scheduler: RTL and testbench

- Sequences the KS0108-style LCD refresh driver against a double-buffered 1024-byte frame store (two banks).
- Generates the periodic frame tick and requests renderer fills of the back bank.
- Swaps banks only between refreshes, and issues the start pulse the driver needs (high for several cycles, then a falling edge).
- Sits between the game renderer, the two frame-buffer RAM banks and the LCD driver.

---
 rtl/lcd_frame_scheduler.sv | 168 ++++++++++++++++
 tb/tb_lcd_frame_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_scheduler.sv
// Frame scheduler for a KS0108-style LCD: paces frames, swaps a double-buffered
// frame store between refreshes and issues the driver's start pulse.
module lcd_frame_scheduler #(
    parameter int unsigned FRAME_PERIOD   = 833334,
    parameter int unsigned REFRESH_CYCLES = 2200,
    parameter int unsigned START_HIGH     = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable_i,
    input  logic       render_done_i,
    output logic       render_req_o,
    output logic       back_bank_o,
    output logic       front_bank_o,
    output logic       drv_start_o,
    input  logic [9:0] drv_addr_i,
    output logic [9:0] bank0_addr_o,
    output logic [9:0] bank1_addr_o,
    input  logic [7:0] bank0_data_i,
    input  logic [7:0] bank1_data_i,
    output logic [7:0] drv_data_o,
    output logic       busy_o,
    output logic [7:0] drop_cnt_o
);

    localparam int unsigned FRAME_W = $clog2(FRAME_PERIOD);
    localparam int unsigned PHASE_W = $clog2(REFRESH_CYCLES);

    typedef enum logic [2:0] {
        INIT,
        WAIT_DONE,
        WAIT_TICK,
        SWAP,
        KICK,
        REFRESH
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [FRAME_W-1:0] frame_cnt;
    logic [PHASE_W-1:0] phase_cnt;
    logic [PHASE_W-1:0] phase_next;
    logic               tick;
    logic               done_flag;
    logic               tick_pending;
    logic               pending_next;
    logic               drop_inc;
    logic               swap_entry;

    // Read path: the driver always reads the front bank
    assign bank0_addr_o = drv_addr_i;
    assign bank1_addr_o = drv_addr_i;
    assign drv_data_o   = front_bank_o ? bank1_data_i : bank0_data_i;

    assign tick       = enable_i && (frame_cnt == FRAME_W'(FRAME_PERIOD - 1));
    assign swap_entry = (state_next == SWAP);

    // Frame period counter, held at zero while scheduling is disabled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_cnt <= '0;
        end else if (!enable_i || tick) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end

    always_comb begin
        state_next   = state;
        phase_next   = phase_cnt;
        pending_next = tick_pending;
        drop_inc     = 1'b0;
        case (state)
            INIT: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tick) begin
                    if (tick_pending) drop_inc = 1'b1;
                    else              pending_next = 1'b1;
                end
                // A late render with a tick already waiting goes straight to the swap
                if (done_flag) begin
                    if (tick_pending && enable_i) begin
                        pending_next = 1'b0;
                        state_next   = SWAP;
                    end else begin
                        state_next = WAIT_TICK;
                    end
                end
            end
            WAIT_TICK: begin
                if (!enable_i) begin
                    pending_next = 1'b0;
                end else if (tick || tick_pending) begin
                    pending_next = 1'b0;
                    state_next   = SWAP;
                end
            end
            SWAP: begin
                drop_inc   = tick;
                phase_next = '0;
                state_next = KICK;
            end
            KICK: begin
                drop_inc = tick;
                if (phase_cnt == PHASE_W'(START_HIGH - 1)) begin
                    phase_next = '0;
                    state_next = REFRESH;
                end else begin
                    phase_next = phase_cnt + PHASE_W'(1);
                end
            end
            REFRESH: begin
                drop_inc = tick;
                if (phase_cnt == PHASE_W'(REFRESH_CYCLES - 1)) begin
                    phase_next = '0;
                    state_next = done_flag ? WAIT_TICK : WAIT_DONE;
                end else begin
                    phase_next = phase_cnt + PHASE_W'(1);
                end
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= INIT;
            phase_cnt    <= '0;
            tick_pending <= 1'b0;
            done_flag    <= 1'b0;
        end else begin
            state        <= state_next;
            phase_cnt    <= phase_next;
            tick_pending <= pending_next;
            // A completion arriving on the swap edge belongs to the new back bank
            done_flag    <= render_done_i | (done_flag & ~swap_entry);
        end
    end

    // Registered outputs, derived from the transition being taken
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            front_bank_o <= 1'b0;
            back_bank_o  <= 1'b1;
            drv_start_o  <= 1'b0;
            render_req_o <= 1'b0;
            busy_o       <= 1'b0;
            drop_cnt_o   <= '0;
        end else begin
            if (swap_entry) begin
                front_bank_o <= ~front_bank_o;
                back_bank_o  <= front_bank_o;
            end
            drv_start_o  <= (state_next == KICK);
            render_req_o <= (state == INIT) || (state == KICK && state_next == REFRESH);
            busy_o       <= (state_next == KICK) || (state_next == REFRESH);
            if (drop_inc && drop_cnt_o != 8'hFF) begin
                drop_cnt_o <= drop_cnt_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Directed bench for lcd_frame_scheduler with a shortened frame period.
module tb_lcd_frame_scheduler;

    localparam int unsigned FRAME_PERIOD   = 5000;
    localparam int unsigned REFRESH_CYCLES = 2200;
    localparam int unsigned START_HIGH     = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       enable_i;
    logic       render_done_i;
    logic       render_req_o;
    logic       back_bank_o;
    logic       front_bank_o;
    logic       drv_start_o;
    logic [9:0] drv_addr_i;
    logic [9:0] bank0_addr_o;
    logic [9:0] bank1_addr_o;
    logic [7:0] bank0_data_i;
    logic [7:0] bank1_data_i;
    logic [7:0] drv_data_o;
    logic       busy_o;
    logic [7:0] drop_cnt_o;

    lcd_frame_scheduler #(
        .FRAME_PERIOD  (FRAME_PERIOD),
        .REFRESH_CYCLES(REFRESH_CYCLES),
        .START_HIGH    (START_HIGH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable_i     (enable_i),
        .render_done_i(render_done_i),
        .render_req_o (render_req_o),
        .back_bank_o  (back_bank_o),
        .front_bank_o (front_bank_o),
        .drv_start_o  (drv_start_o),
        .drv_addr_i   (drv_addr_i),
        .bank0_addr_o (bank0_addr_o),
        .bank1_addr_o (bank1_addr_o),
        .bank0_data_i (bank0_data_i),
        .bank1_data_i (bank1_data_i),
        .drv_data_o   (drv_data_o),
        .busy_o       (busy_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] exp_f0;
        logic [7:0] exp_f1;
    } rd_vec_t;

    rd_vec_t vecs[4];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   start_hi = 0;
    int   fb_moves = 0;
    logic last_front;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance to cycle c, sampling 1ns after each rising edge and watching the driver lines
    task automatic run_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            cyc++;
            if (drv_start_o === 1'b1) start_hi++;
            if (front_bank_o !== last_front) fb_moves++;
            last_front = front_bank_o;
        end
    endtask

    task automatic pulse_done(input int c);
        run_to(c);
        render_done_i = 1'b1;
        run_to(c + 1);
        render_done_i = 1'b0;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn       = 1'b1;
        cyc        = 0;
        last_front = front_bank_o;
    endtask

    // Read path vectors; fb is the front bank the bench expects at this point
    task automatic run_table(input logic fb);
        for (int i = 0; i < 4; i++) begin
            drv_addr_i   = vecs[i].addr;
            bank0_data_i = vecs[i].d0;
            bank1_data_i = vecs[i].d1;
            #1;
            check($sformatf("rd_data[%0d]", i), 32'(drv_data_o), 32'(fb ? vecs[i].exp_f1 : vecs[i].exp_f0));
            check($sformatf("rd_addr0[%0d]", i), 32'(bank0_addr_o), 32'(vecs[i].addr));
            check($sformatf("rd_addr1[%0d]", i), 32'(bank1_addr_o), 32'(vecs[i].addr));
        end
    endtask

    initial begin
        vecs[0] = '{addr: 10'h3C5, d0: 8'h00, d1: 8'hA5, exp_f0: 8'h00, exp_f1: 8'hA5};
        vecs[1] = '{addr: 10'h000, d0: 8'h5A, d1: 8'hC3, exp_f0: 8'h5A, exp_f1: 8'hC3};
        vecs[2] = '{addr: 10'h3FF, d0: 8'hFF, d1: 8'h01, exp_f0: 8'hFF, exp_f1: 8'h01};
        vecs[3] = '{addr: 10'h155, d0: 8'h81, d1: 8'h7E, exp_f0: 8'h81, exp_f1: 8'h7E};

        enable_i      = 1'b1;
        render_done_i = 1'b0;
        drv_addr_i    = '0;
        bank0_data_i  = '0;
        bank1_data_i  = '0;
        apply_reset();

        // Reset state and first render request
        check("rst_front", 32'(front_bank_o), 32'd0);
        check("rst_back", 32'(back_bank_o), 32'd1);
        check("rst_start", 32'(drv_start_o), 32'd0);
        check("rst_req", 32'(render_req_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_drop", 32'(drop_cnt_o), 32'd0);
        run_to(1);
        check("req_c1", 32'(render_req_o), 32'd1);
        run_to(2);
        check("req_c2", 32'(render_req_o), 32'd0);

        // Normal frame: render done early, swap on the first tick
        pulse_done(100);
        run_to(4999);
        check("pre_swap_front", 32'(front_bank_o), 32'd0);
        check("pre_swap_start_hi", 32'(start_hi), 32'd0);
        run_to(5000);
        check("swap_front", 32'(front_bank_o), 32'd1);
        check("swap_back", 32'(back_bank_o), 32'd0);
        check("swap_start", 32'(drv_start_o), 32'd0);
        run_to(5001);
        check("kick_start", 32'(drv_start_o), 32'd1);
        check("kick_busy", 32'(busy_o), 32'd1);
        run_to(5004);
        check("kick_last", 32'(drv_start_o), 32'd1);
        run_to(5005);
        check("fall_start", 32'(drv_start_o), 32'd0);
        check("fall_req", 32'(render_req_o), 32'd1);
        check("fall_start_hi", 32'(start_hi), 32'd4);
        run_to(5006);
        check("req_one_cycle", 32'(render_req_o), 32'd0);
        run_to(7204);
        check("refresh_busy", 32'(busy_o), 32'd1);
        run_to(7205);
        check("refresh_end_busy", 32'(busy_o), 32'd0);

        run_table(1'b1);

        // Late render: tick pends, swap as soon as the render completes
        run_to(10000);
        check("pend_drop", 32'(drop_cnt_o), 32'd0);
        check("pend_front", 32'(front_bank_o), 32'd1);
        pulse_done(11000);
        check("late_pre_front", 32'(front_bank_o), 32'd1);
        run_to(11002);
        check("late_swap_front", 32'(front_bank_o), 32'd0);
        run_to(11003);
        check("late_kick", 32'(drv_start_o), 32'd1);
        run_to(11007);
        check("late_fall", 32'(drv_start_o), 32'd0);
        check("late_req", 32'(render_req_o), 32'd1);
        run_to(13207);
        check("late_busy_end", 32'(busy_o), 32'd0);

        run_table(1'b0);

        // Render stalls across three ticks: one pends, two drop
        start_hi = 0;
        fb_moves = 0;
        run_to(15000);
        check("stall_drop0", 32'(drop_cnt_o), 32'd0);
        run_to(20000);
        check("stall_drop1", 32'(drop_cnt_o), 32'd1);
        run_to(25000);
        check("stall_drop2", 32'(drop_cnt_o), 32'd2);
        check("stall_no_start", 32'(start_hi), 32'd0);
        check("stall_no_swap", 32'(fb_moves), 32'd0);

        // Render completes; disable mid-refresh and confirm the scheduler goes quiet
        pulse_done(25100);
        run_to(25102);
        check("resume_front", 32'(front_bank_o), 32'd1);
        run_to(26000);
        enable_i = 1'b0;
        run_to(27306);
        check("dis_busy_tail", 32'(busy_o), 32'd1);
        run_to(27307);
        check("dis_busy_end", 32'(busy_o), 32'd0);
        start_hi = 0;
        fb_moves = 0;
        run_to(40000);
        check("dis_no_start", 32'(start_hi), 32'd0);
        check("dis_no_swap", 32'(fb_moves), 32'd0);
        check("dis_drop", 32'(drop_cnt_o), 32'd2);

        // Reset during KICK
        enable_i = 1'b1;
        apply_reset();
        check("rst2_drop", 32'(drop_cnt_o), 32'd0);
        pulse_done(10);
        run_to(5002);
        check("kick2_start", 32'(drv_start_o), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        check("midkick_start", 32'(drv_start_o), 32'd0);
        check("midkick_front", 32'(front_bank_o), 32'd0);
        check("midkick_back", 32'(back_bank_o), 32'd1);
        check("midkick_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rstn       = 1'b1;
        cyc        = 0;
        last_front = front_bank_o;
        check("rerst_req_c0", 32'(render_req_o), 32'd0);
        run_to(1);
        check("rerst_req_c1", 32'(render_req_o), 32'd1);
        run_to(2);
        check("rerst_req_c2", 32'(render_req_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
